// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a per-grant hold limit.
// One owner at a time; every release returns to IDLE for at least one cycle.
module rr_arbiter_8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       busy,
   output logic       timeout
);

   localparam int NUM_REQ = 8;
   localparam int HW      = $clog2(MAX_HOLD);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [7:0]      gnt_q, gnt_d;
   logic [2:0]      id_q, id_d;
   logic            to_q, to_d;

   // Candidate j is the requester j+1 places after the last winner.
   logic [NUM_REQ-1:0][2:0] cand_idx;
   logic [NUM_REQ-1:0]      rot_req;
   logic [2:0]              win_id;

   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_cand
         assign cand_idx[g] = ptr_q + 3'(g + 1);
         assign rot_req[g]  = req[cand_idx[g]];
      end
   endgenerate

   always_comb begin
      win_id = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--)
         if (rot_req[j]) win_id = cand_idx[j];
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 3'd7;
         hold_q  <= '0;
         gnt_q   <= '0;
         id_q    <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         to_q    <= to_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      to_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               id_d    = win_id;
               gnt_d   = 8'd1 << win_id;
               hold_d  = '0;
            end
         end
         GRANT: begin
            // A normal release wins over the hold limit, so no timeout then.
            if (done || !req[id_q] || hold_q == HW'(MAX_HOLD - 1)) begin
               state_d = IDLE;
               ptr_d   = id_q;
               hold_d  = '0;
               gnt_d   = '0;
               id_d    = '0;
               to_d    = !(done || !req[id_q]);
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      gnt     = gnt_q;
      gnt_id  = id_q;
      busy    = (state_q == GRANT);
      timeout = to_q;
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: fixed stimulus steps with hand-computed outputs.
module tb_rr_arbiter_8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       busy;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   rr_arbiter_8 #(.MAX_HOLD(16)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                      input logic eb, input logic et);
      checks++;
      assert ({gnt, gnt_id, busy, timeout} === {eg, ei, eb, et}) else begin
         errors++;
         $error("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                tag, gnt, gnt_id, busy, timeout, eg, ei, eb, et);
      end
   endtask

   initial begin
      rst = 1'b1; req = 8'h00; done = 1'b0;
      step(); step();
      chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);

      // Basic grant/release; first edge with rst low makes the decision
      rst = 1'b0; req = 8'h01;
      step();
      chk("basic_grant", 8'h01, 3'd0, 1'b1, 1'b0);
      done = 1'b1;
      step();
      chk("basic_release", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b0; req = 8'h00;
      step();
      chk("idle_no_req", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b1;
      step();
      chk("done_in_idle", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b0;

      // Full rotation from reset
      rst = 1'b1;
      step();
      rst = 1'b0; req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         step();
         chk($sformatf("rot_grant%0d", i), 8'd1 << (i % 8), 3'(i % 8), 1'b1, 1'b0);
         done = 1'b1;
         step();
         chk($sformatf("rot_idle%0d", i), 8'h00, 3'd0, 1'b0, 1'b0);
         done = 1'b0;
      end

      // Wrap-around: last grant to 2, then req 0 and 2
      req = 8'h04;
      step();
      chk("wrap_setup", 8'h04, 3'd2, 1'b1, 1'b0);
      done = 1'b1;
      step();
      done = 1'b0; req = 8'h05;
      step();
      chk("wrap_grant0", 8'h01, 3'd0, 1'b1, 1'b0);
      done = 1'b1;
      step();
      chk("wrap_release", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b0;
      step();
      chk("wrap_grant2", 8'h04, 3'd2, 1'b1, 1'b0);
      req = 8'hF5;
      step();
      chk("stable_other_req", 8'h04, 3'd2, 1'b1, 1'b0);
      done = 1'b1;
      step();
      done = 1'b0;

      // Hold limit with requesters 0 and 3
      rst = 1'b1;
      step();
      rst = 1'b0; req = 8'h09;
      step();
      chk("hold_start", 8'h01, 3'd0, 1'b1, 1'b0);
      for (int i = 1; i < 16; i++) begin
         step();
         chk($sformatf("hold_cyc%0d", i), 8'h01, 3'd0, 1'b1, 1'b0);
      end
      step();
      chk("timeout_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
      step();
      chk("after_timeout", 8'h08, 3'd3, 1'b1, 1'b0);

      // done coincides with the hold limit: plain release
      for (int i = 1; i < 16; i++) step();
      chk("hold3_last", 8'h08, 3'd3, 1'b1, 1'b0);
      done = 1'b1;
      step();
      chk("done_at_limit", 8'h00, 3'd0, 1'b0, 1'b0);
      done = 1'b0; req = 8'hFF;
      step();
      chk("next_after_3", 8'h10, 3'd4, 1'b1, 1'b0);

      // Requester 4 drops its request mid-grant
      req = 8'hEF;
      step();
      chk("drop_release", 8'h00, 3'd0, 1'b0, 1'b0);
      step();
      chk("grant_after_drop", 8'h20, 3'd5, 1'b1, 1'b0);

      // Reset mid-grant to 5
      req = 8'hFF; rst = 1'b1;
      step();
      chk("reset_mid_grant", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk("grant_after_reset", 8'h01, 3'd0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
